// File: rtl/decodificador_stream.sv
// Streaming one-hot / thermometer decoder with a single-entry output register and valid/ready flow.
// Optional macro DECOD_ERRCNT_EN adds a saturating counter of accepted out-of-range codes.
module decodificador_stream #(
    parameter int IN_W  = 4,
    parameter int OUT_N = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_mode,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_N-1:0] out_lines,
    output logic             out_err,
    output logic [7:0]       err_cnt
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic             accept;
    logic             in_range;
    logic [OUT_N-1:0] dec_lines;
    logic [OUT_N-1:0] lines_q, lines_d;
    logic             err_q, err_d;

    assign in_ready = (state_q == StEmpty) | out_ready;
    assign accept   = in_valid & in_ready;

    // Combinational decode of the presented code; only captured on accept.
    always_comb begin
        in_range  = (int'(in_code) < OUT_N);
        dec_lines = '0;
        for (int i = 0; i < OUT_N; i++) begin
            if (in_mode) begin
                dec_lines[i] = (i <= int'(in_code));
            end else begin
                dec_lines[i] = (i == int'(in_code));
            end
        end
        if (!in_range) begin
            dec_lines = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        lines_d = lines_q;
        err_d   = err_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull;
                    lines_d = dec_lines;
                    err_d   = ~in_range;
                end
            end
            StFull: begin
                // A new accept while full replaces the result without a bubble.
                if (accept) begin
                    lines_d = dec_lines;
                    err_d   = ~in_range;
                end else if (out_ready) begin
                    state_d = StEmpty;
                    lines_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            lines_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lines_q <= lines_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_lines = out_valid ? lines_q : '0;
    assign out_err   = out_valid & err_q;

`ifdef DECOD_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (accept && !in_range && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_decodificador_stream.sv
// Directed bench for decodificador_stream with immediate-assertion checks.
module tb_decodificador_stream;

    localparam int IN_W  = 4;
    localparam int OUT_N = 5;
`ifdef DECOD_ERRCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [IN_W-1:0]  in_code;
    logic             in_mode;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_N-1:0] out_lines;
    logic             out_err;
    logic [7:0]       err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decodificador_stream #(
        .IN_W (IN_W),
        .OUT_N(OUT_N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_code  (in_code),
        .in_mode  (in_mode),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_lines(out_lines),
        .out_err  (out_err),
        .err_cnt  (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [OUT_N-1:0] exp_lines;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_lines", out_lines, 0);
        check("rst_err", out_err, 0);
        check("rst_cnt", err_cnt, 0);

        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);

        // One-hot sweep, back-to-back
        in_valid = 1'b1;
        in_mode  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_code = 4'(c);
            tick();
            exp_lines = 5'b00001 << c;
            check("onehot_valid", out_valid, 1);
            check("onehot_lines", out_lines, exp_lines);
            check("onehot_err", out_err, 0);
        end

        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_lines", out_lines, 0);

        // Code changes without in_valid are ignored
        in_code = 4'd2;
        tick();
        check("idle_valid", out_valid, 0);
        check("idle_lines", out_lines, 0);

        // Thermometer
        in_valid = 1'b1;
        in_mode  = 1'b1;
        in_code  = 4'd3;
        tick();
        check("thermo3", out_lines, 5'b01111);
        in_code = 4'd0;
        tick();
        check("thermo0", out_lines, 5'b00001);
        in_code = 4'd4;
        tick();
        check("thermo4", out_lines, 5'b11111);
        check("thermo4_err", out_err, 0);

        // Out-of-range codes
        in_mode = 1'b0;
        in_code = 4'd9;
        tick();
        check("oor9_lines", out_lines, 0);
        check("oor9_err", out_err, 1);
        check("oor9_cnt", err_cnt, CNT_ON ? 1 : 0);
        in_mode = 1'b1;
        in_code = 4'd5;
        tick();
        check("oor5_lines", out_lines, 0);
        check("oor5_err", out_err, 1);
        check("oor5_cnt", err_cnt, CNT_ON ? 2 : 0);

        in_valid = 1'b0;
        tick();
        check("drain2_valid", out_valid, 0);
        check("drain2_err", out_err, 0);

        // Stall with a pending code
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_code  = 4'd2;
        tick();
        check("stall_first", out_lines, 5'b00100);
        out_ready = 1'b0;
        in_code   = 4'd4;
        #1;
        check("stall_ready0", in_ready, 0);
        repeat (3) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_lines", out_lines, 5'b00100);
            check("stall_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", in_ready, 1);
        tick();
        check("release_lines", out_lines, 5'b10000);
        check("release_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();
        check("drain3_valid", out_valid, 0);

        // Error counter saturation
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_code  = 4'd15;
        repeat (100) @(posedge clk);
        #1;
        check("cnt_102", err_cnt, CNT_ON ? 102 : 0);
        repeat (200) @(posedge clk);
        #1;
        check("cnt_sat", err_cnt, CNT_ON ? 255 : 0);
        check("sat_err", out_err, 1);

        // Reset while full and stalled; the presented code is discarded
        out_ready = 1'b0;
        in_code   = 4'd3;
        tick();
        check("prerst_valid", out_valid, 1);
        check("prerst_err", out_err, 1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_lines", out_lines, 0);
        check("midrst_err", out_err, 0);
        check("midrst_cnt", err_cnt, 0);
        check("midrst_ready", in_ready, 1);
        tick();
        check("midrst_discard", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
